// File: rtl/ahb_apb_pkg.sv
// Shared encodings, FSM state type and elaboration helpers for the multi-slave
// AHB-to-APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    // Ceiling log2, never less than 1 so that derived vectors stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational APB slave decode: picks the slave index field out of the AHB
// address and produces the index, a one-hot select and an in-range flag.
module apb_slave_decode
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NSLV    = 3,
    parameter int unsigned SEL_LSB = 12,
    localparam int unsigned IDXW   = clog2(NSLV)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDXW-1:0]   idx_o,
    output logic [NSLV-1:0]   onehot_o,
    output logic              valid_o
);

    always_comb begin
        idx_o    = IDXW'(addr_i >> SEL_LSB);
        valid_o  = 32'(idx_o) < NSLV;
        onehot_o = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            onehot_o[i] = (32'(idx_o) == i);
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-to-APB bridge for NSLV APB slaves: one APB SETUP/ACCESS per accepted AHB
// transfer, with PREADY wait states, PSLVERR/decode/timeout errors as a 2-cycle ERROR.
module ahb_apb_bridge_mslv
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 3,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic                   HWRITE,
    input  logic [1:0]             HTRANS,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic                   HREADYIN,
    output logic                   HREADYOUT,
    output logic [1:0]             HRESP,
    output logic [DATA_W-1:0]      HRDATA,
    output logic [NSLV-1:0]        PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int unsigned IDXW = clog2(NSLV);
    localparam int unsigned CNTW = clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                hready_q, hready_d;
    logic [1:0]          hresp_q, hresp_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic [NSLV-1:0]     psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [NSLV-1:0]     sel_q, sel_d;
    logic                valid_q, valid_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    logic [IDXW-1:0]     dec_idx;
    logic [NSLV-1:0]     dec_onehot;
    logic                dec_valid;
    logic                accept, slv_ready, slv_err, timeout_hit;
    logic [DATA_W-1:0]   slv_rdata;

    apb_slave_decode #(
        .ADDR_W  (ADDR_W),
        .NSLV    (NSLV),
        .SEL_LSB (SEL_LSB)
    ) u_decode (
        .addr_i   (HADDR),
        .idx_o    (dec_idx),
        .onehot_o (dec_onehot),
        .valid_o  (dec_valid)
    );

    assign accept = HSEL && HREADYIN && htrans_active(HTRANS) && hready_q;

    // Response of the addressed slave; only consulted in ACCESS, where idx_q is in range.
    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (32'(idx_q) == i) begin
                slv_ready = PREADY[i];
                slv_err   = PSLVERR[i];
                slv_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT);

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        hrdata_d  = hrdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            // Both states present HREADYOUT=1, so either can take the next transfer.
            StIdle, StErr2: begin
                state_d = StIdle;
                hresp_d = HRESP_OKAY;
                if (accept) begin
                    state_d  = StLatch;
                    hready_d = 1'b0;
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    idx_d    = dec_idx;
                    sel_d    = dec_onehot;
                    valid_d  = dec_valid;
                end
            end
            StLatch: begin
                pwdata_d = HWDATA;
                if (valid_q) begin
                    psel_d  = sel_q;
                    state_d = StSetup;
                end else begin
                    hresp_d = HRESP_ERROR;
                    state_d = StErr1;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (slv_ready || timeout_hit) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                end
                if (slv_ready && !slv_err) begin
                    if (!pwrite_q) hrdata_d = slv_rdata;
                    hready_d = 1'b1;
                    state_d  = StIdle;
                end else if (slv_ready || timeout_hit) begin
                    hresp_d = HRESP_ERROR;
                    state_d = StErr1;
                end else if (cnt_q != {CNTW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StErr1: begin
                hready_d = 1'b1;
                state_d  = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Scoreboard bench for ahb_apb_bridge_mslv: driver pushes expected AHB responses and
// APB transfers; an AHB monitor and an APB slave model pop and compare.
module tb_ahb_apb_bridge_mslv;
    import ahb_apb_pkg::*;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned SL = 12;
    localparam int unsigned TO = 8;

    logic             HCLK = 1'b0;
    logic             HRESET, HSEL, HWRITE, HREADYIN, HREADYOUT, PENABLE, PWRITE;
    logic [1:0]       HTRANS, HRESP;
    logic [31:0]      HADDR, HWDATA, HRDATA, PADDR, PWDATA;
    logic [NS-1:0]    PSEL, PREADY, PSLVERR;
    logic [NS*DW-1:0] PRDATA;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_mslv #(
        .ADDR_W  (32),
        .DATA_W  (DW),
        .NSLV    (NS),
        .SEL_LSB (SL),
        .TIMEOUT (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          low;
    } rsp_t;

    xfer_t       apb_q[$];
    rsp_t        rsp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata;
    bit          mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void flag(string name, string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endfunction

    // Expected outcome is derived from the transfer rules, not from bridge state.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input int waits, input logic err, input logic [31:0] rdata);
        xfer_t x;
        rsp_t  r;
        int    g;
        int    idx;
        g = 0;
        while (HREADYOUT !== 1'b1 && g < 200) begin
            @(negedge HCLK);
            g++;
        end
        if (g >= 200) flag("accept_wait", "HREADYOUT never returned high");
        x   = '{addr, wr, wdata, waits, err, rdata};
        idx = int'(addr[SL +: 2]);
        if (idx >= int'(NS)) begin
            r.resp = HRESP_ERROR;
            r.low  = 2;
        end else begin
            apb_q.push_back(x);
            if (waits >= int'(TO)) begin
                r.resp = HRESP_ERROR;
                r.low  = 3 + int'(TO);
            end else if (err) begin
                r.resp = HRESP_ERROR;
                r.low  = 4 + waits;
            end else begin
                r.resp = HRESP_OKAY;
                r.low  = 3 + waits;
                if (!wr) last_rdata = rdata;
            end
        end
        r.rdata = last_rdata;
        rsp_q.push_back(r);
        HSEL     = 1'b1;
        HREADYIN = 1'b1;
        HTRANS   = ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
        HADDR    = addr;
        HWRITE   = wr;
        @(posedge HCLK);
        @(negedge HCLK);
        HWDATA = wdata;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'($urandom);
        HADDR  = $urandom;
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
                0: begin HSEL = 1'b1; HTRANS = HTRANS_IDLE; end
                1: begin HSEL = 1'b1; HTRANS = HTRANS_BUSY; end
                2: begin HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; end
                default: begin HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HREADYIN = 1'b0; end
            endcase
            @(negedge HCLK);
        end
        HREADYIN = 1'b1;
        HTRANS   = HTRANS_IDLE;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (HREADYOUT !== 1'b1 && g < 50) begin
            @(negedge HCLK);
            g++;
        end
        if (g >= 50) flag("ready_wait", "HREADYOUT stuck low");
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rsp_q.size() != 0 || HREADYOUT !== 1'b1) && g < 300) begin
            @(negedge HCLK);
            g++;
        end
        if (g >= 300) flag("drain", "responses still outstanding");
        chk("apb_q_drained", apb_q.size(), 0);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_hreadyout"}, HREADYOUT, 1);
        chk({p, "_hresp"}, HRESP, HRESP_OKAY);
        chk({p, "_hrdata"}, HRDATA, 0);
        chk({p, "_psel"}, PSEL, 0);
        chk({p, "_penable"}, PENABLE, 0);
        chk({p, "_pwrite"}, PWRITE, 0);
        chk({p, "_paddr"}, PADDR, 0);
        chk({p, "_pwdata"}, PWDATA, 0);
    endtask

    // AHB monitor: one response per HREADYOUT low->high run.
    initial begin : monitor
        int         low;
        logic [1:0] last_resp;
        rsp_t       e;
        low       = 0;
        last_resp = '0;
        forever begin
            @(negedge HCLK);
            if (!mon_en) begin
                low = 0;
            end else if (HREADYOUT !== 1'b1) begin
                low++;
                last_resp = HRESP;
            end else if (low == 0) begin
                chk("idle_hresp", HRESP, HRESP_OKAY);
            end else begin
                if (rsp_q.size() == 0) begin
                    flag("rsp_unexpected", "data phase completed with nothing outstanding");
                end else begin
                    e = rsp_q.pop_front();
                    chk("hresp", HRESP, e.resp);
                    chk("hrdata", HRDATA, e.rdata);
                    chk("wait_states", low, e.low);
                    chk("last_wait_hresp", last_resp, e.resp);
                end
                low = 0;
            end
        end
    end

    // APB slave model: checks SETUP contents and answers after the scripted waits.
    initial begin : slave
        xfer_t            cur;
        int               j;
        int               idx;
        bit               active;
        logic [NS-1:0]    oh;
        logic [NS*DW-1:0] rd;
        active  = 1'b0;
        j       = 0;
        idx     = 0;
        oh      = '0;
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        forever begin
            @(negedge HCLK);
            PREADY  = NS'($urandom);
            PSLVERR = NS'($urandom);
            rd      = {$urandom, $urandom, $urandom};
            if (PSEL == '0) begin
                active = 1'b0;
            end else if (!PENABLE) begin
                if (apb_q.size() == 0) begin
                    flag("apb_unexpected", $sformatf("PSEL=%b with no transfer due", PSEL));
                end else begin
                    cur    = apb_q.pop_front();
                    idx    = int'(cur.addr[SL +: 2]);
                    oh     = NS'(1) << idx;
                    active = 1'b1;
                    j      = 0;
                    chk("psel_setup", PSEL, oh);
                    chk("paddr", PADDR, cur.addr);
                    chk("pwrite", PWRITE, cur.wr);
                    if (cur.wr) chk("pwdata", PWDATA, cur.wdata);
                end
            end else if (active) begin
                chk("psel_access", PSEL, oh);
                PREADY[idx]          = (j == cur.waits);
                PSLVERR[idx]         = cur.err && (j == cur.waits);
                rd[idx*DW +: DW]     = cur.rdata;
                j++;
            end
            PRDATA = rd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int g;
        HRESET     = 1'b1;
        HSEL       = 1'b0;
        HADDR      = '0;
        HWRITE     = 1'b0;
        HTRANS     = HTRANS_IDLE;
        HWDATA     = '0;
        HREADYIN   = 1'b1;
        last_rdata = '0;
        repeat (3) @(posedge HCLK);
        #1 check_reset("reset");
        @(negedge HCLK);
        HRESET = 1'b0;
        mon_en = 1'b1;

        issue(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        issue(32'h0000_2000, 1'b0, 32'h0, 4, 1'b0, 32'h1234_5678);
        issue(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
        issue(32'h0000_0008, 1'b1, 32'hCAFE_0001, 1, 1'b1, 32'h0);
        wait_ready();
        chk("err2_b2b_hresp", HRESP, HRESP_ERROR);
        issue(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_A5A5);
        issue(32'h0000_1100, 1'b0, 32'h0, 30, 1'b0, 32'h5555_5555);
        issue(32'h0000_2010, 1'b0, 32'h0, 7, 1'b0, 32'h7777_7777);
        idle_gap(3);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          w;
            a         = $urandom;
            a[SL +: 2] = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 10))
                                            : int'($urandom_range(0, 3));
            issue(a, 1'($urandom), $urandom, w, ($urandom_range(0, 5) == 0), $urandom);
            idle_gap(int'($urandom_range(0, 2)));
        end
        drain();

        // Reset in the middle of an ACCESS phase: transfer dropped, no response.
        mon_en = 1'b0;
        issue(32'h0000_1040, 1'b0, 32'h0, 30, 1'b0, 32'h0000_0001);
        g = 0;
        while (PENABLE !== 1'b1 && g < 20) begin
            @(negedge HCLK);
            g++;
        end
        chk("rst_reached_access", PENABLE, 1);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1 check_reset("midrst");
        @(negedge HCLK);
        HRESET = 1'b0;
        rsp_q.delete();
        apb_q.delete();
        last_rdata = '0;
        HSEL       = 1'b1;
        HTRANS     = HTRANS_IDLE;
        repeat (3) begin
            @(posedge HCLK);
            #1;
            chk("postrst_hreadyout", HREADYOUT, 1);
            chk("postrst_hresp", HRESP, HRESP_OKAY);
            chk("postrst_psel", PSEL, 0);
        end
        @(negedge HCLK);
        mon_en = 1'b1;

        for (int n = 0; n < 10; n++) begin
            logic [31:0] a;
            a          = $urandom;
            a[SL +: 2] = 2'($urandom_range(0, 3));
            issue(a, 1'($urandom), $urandom, int'($urandom_range(0, 2)), 1'b0, $urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_mslv.md
# ahb_apb_bridge_mslv

Parametrised AHB-to-APB bridge: next generation of the single-slave bridge, serving NSLV APB slaves with per-slave address decode, PREADY wait states, PSLVERR-to-HRESP error mapping and an optional PREADY timeout. Sits between the AHB master and the APB peripherals. Converts each accepted AHB NONSEQ/SEQ transfer into one APB SETUP/ACCESS transfer and stalls the AHB data phase with HREADYOUT.

## Interface
Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, data width
- NSLV, 3, number of APB slaves (1..16)
- SEL_LSB, 12, lowest HADDR bit of the slave index field; field width IDXW = clog2(NSLV) (min 1)
- TIMEOUT, 0, max ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  reset; one clock; reset is synchronous and active-high
- HSEL  in  1  bridge selected
- HADDR  in  ADDR_W  AHB address
- HWRITE  in  1  1 = write
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWDATA  in  DATA_W  write data, valid in data phase
- HREADYIN  in  1  bus ready
- HREADYOUT  out  1  data phase complete
- HRESP  out  2  00 OKAY, 01 ERROR
- HRDATA  out  DATA_W  read data
- PSEL  out  NSLV  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  NSLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
- PREADY  in  NSLV  per-slave ready
- PSLVERR  in  NSLV  per-slave error

## Operation
- Accept when HSEL & HREADYIN & HTRANS[1] & HREADYOUT: register HADDR, HWRITE, decoded index and valid flag; go LATCH.
- IDLE/BUSY transfers are not accepted; zero-wait OKAY response, no APB activity.
- Decode: idx = HADDR[SEL_LSB +: IDXW]; valid iff idx < NSLV.
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- LATCH: HREADYOUT=0; capture HWDATA into PWDATA register. Transition to SETUP if valid, else to ERR1 (no PSEL ever asserted).
- SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA stable. Always transitions to ACCESS.
- ACCESS: PENABLE=1. Sample PREADY[idx], PSLVERR[idx] and PRDATA slice idx.
  - PREADY=1, PSLVERR=0: HRDATA<=PRDATA slice (reads only; writes leave HRDATA unchanged), HREADYOUT<=1, HRESP<=OKAY, PSEL/PENABLE<=0; go IDLE.
  - PREADY=1, PSLVERR=1: PSEL/PENABLE<=0; go ERR1.
  - PREADY=0: stay in ACCESS; increment the wait counter.
  - TIMEOUT>0 and counter reaches TIMEOUT with PREADY=0: abandon (PSEL/PENABLE<=0); go ERR1.
- ERR1: HREADYOUT=0, HRESP=ERROR. ERR2: HREADYOUT=1, HRESP=ERROR; then IDLE (HRESP returns to OKAY).
- Back-to-back: a new transfer may be accepted in the cycle HREADYOUT=1 ends the previous one, including ERR2.
- PADDR carries full HADDR; address bits are not stripped.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; state IDLE; counter 0.
- Reset mid-transfer: all of the above at the next edge; the APB transfer is abandoned and no response is given.
- All outputs are registered.
- Latency, accept edge k, zero-wait slave: LATCH k+1, SETUP k+2, ACCESS k+3, HREADYOUT=1 during k+4. That is 3 wait states, plus 1 per PREADY=0 cycle.
- Decode error: ERR1 at k+2, ERR2 at k+3.
- Wait counter: clog2(TIMEOUT+1) bits; cleared on entering ACCESS; saturates.

## Structure
- Package ahb_apb_pkg: HTRANS and HRESP encodings, state enum, clog2 helper.
- One sub-module apb_slave_decode: HADDR to idx, one-hot, valid. Combinational, parametrised by NSLV and SEL_LSB.

## Test plan
- Write, NSLV=3, HADDR=0x0000_1004, HWDATA=0xDEAD_BEEF: PSEL=3'b010, PADDR=0x1004, PWDATA=0xDEADBEEF, PENABLE for 1 cycle, HREADYOUT low 3 cycles, HRESP OKAY.
- Read slave 2 with PREADY held low 4 cycles, PRDATA=0x1234_5678: ACCESS lasts 5 cycles, HRDATA=0x12345678 when HREADYOUT rises.
- Address 0x0000_3000 (idx 3 ≥ NSLV): PSEL stays 0; ERR1 then ERR2 two-cycle ERROR response.
- PSLVERR=1 with PREADY=1 on a write to slave 0: two-cycle ERROR response; next NONSEQ accepted in ERR2 cycle.
- TIMEOUT=8, PREADY stuck low: PENABLE drops after 8 ACCESS cycles, then ERROR response.
- HRESET asserted during ACCESS: next edge all outputs at reset values; HTRANS=IDLE afterwards gives OKAY with no wait.
